nixie_capture: RTL and testbench
================================

NIXIE_CAPTURE -- requirements
Module: nixie_capture

Interface
REQ-001 Parameter STABLE_CYC, default 16: cycles a one-hot digit enable and segment bus must hold unchanged before the digit is captured.
REQ-002 Parameter TIMEOUT_CYC, default 1048576: cycles without any capture before scan_lost asserts.
REQ-003 sys_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 sys_rst  input  1  reset, asynchronous, active-high.
REQ-005 dig_en  input  8  digit enables, active-high; bit7..0 = h_qw,h_bw,h_sw,h_gw,l_qw,l_bw,l_sw,l_gw.
REQ-006 smg  input  8  segment bus, active-high; bit0..6 = segments a..g, bit7 = dp.
REQ-007 data  output  32  captured frame, nibble i = digit i (nibble 7 = h_qw).
REQ-008 blank_mask  output  8  bit i set = digit i was blank in the last frame.
REQ-009 glyph_err  output  8  bit i set = digit i showed an unrecognised pattern in the last frame.
REQ-010 dp_mask  output  8  bit i set = dp lit on digit i in the last frame (see Configuration).
REQ-011 frame_valid  output  1  one-cycle pulse when data/masks update.
REQ-012 overlap_err  output  1  sticky: more than one enable seen active at once.
REQ-013 scan_lost  output  1  level: no capture for TIMEOUT_CYC cycles.

Function
REQ-014 Inputs SHALL pass through a 2-flop synchroniser; all timing below counts from synchronised values.
REQ-015 FSM states IDLE, SETTLE, HOLD; IDLE when dig_en is all-zero.
REQ-016 IDLE -> SETTLE when dig_en is one-hot; the stability counter loads 1 and the enable/segment values are latched.
REQ-017 In SETTLE, any change of dig_en or smg restarts the counter at 1 with the new values; dig_en all-zero returns to IDLE.
REQ-018 SETTLE -> HOLD when the counter reaches STABLE_CYC; in that cycle the digit is decoded into the shadow slot and its seen bit set.
REQ-019 HOLD -> IDLE on any dig_en change; a digit is captured at most once per enable assertion.
REQ-020 Multi-hot dig_en in any state: set overlap_err, go to IDLE, no capture.
REQ-021 Decode: 0x3F,0x06,0x5B,0x4F,0x66,0x6D,0x7D,0x07,0x7F,0x6F -> 0..9; 0x00 -> nibble 0xF with blank bit; any other pattern -> nibble 0xE with glyph_err bit (dp ignored for decode).
REQ-022 When the capture completes seen = 8'hFF, the next cycle SHALL copy shadow to data/masks, pulse frame_valid, and clear seen; a capture in that same cycle goes to the new frame.
REQ-023 Recapturing a digit already seen in the current frame SHALL overwrite its shadow slot without affecting seen.
REQ-024 Timeout counter clears on every capture, saturates at TIMEOUT_CYC; scan_lost = (counter == TIMEOUT_CYC); data retains last frame.
REQ-025 overlap_err clears only on reset.

Reset
REQ-026 On sys_rst: data = 32'hFFFF_FFFF, blank_mask = 8'hFF, glyph_err = 0, dp_mask = 0, frame_valid = 0, overlap_err = 0, scan_lost = 0, seen = 0, FSM = IDLE, counters = 0, synchronisers = 0.
REQ-027 Reset asserted mid-frame SHALL discard the partial frame; no frame_valid until 8 fresh captures after release.

Configuration
REQ-028 Macro NIXIE_CAPTURE_DP_EN defined: dp bit captured per digit into dp_mask on frame update.
REQ-029 Macro undefined: no dp storage is built; dp_mask is constant 0; smg bit7 still ignored for decode.

Verification
REQ-030 Scan digits 7..0 with 0x06,0x5B,0x4F,0x66,0x6D,0x7D,0x07,0x7F, 40 cycles each -> frame_valid once, data = 32'h1234_5678, masks 0.
REQ-031 Digit 3 enabled 10 cycles only (STABLE_CYC=16) within an otherwise valid scan -> no frame_valid until digit 3 held >=16 cycles.
REQ-032 dig_en = 8'h03 for 1 cycle -> overlap_err = 1 and stays 1; no capture that cycle.
REQ-033 Digit 5 pattern 0x49, digit 0 pattern 0x00, others 0x3F -> data = 32'h00E0_000F, glyph_err = 8'h20, blank_mask = 8'h01.
REQ-034 With NIXIE_CAPTURE_DP_EN, smg = 0xBF on digit 2 -> data nibble 2 = 0, dp_mask = 8'h04; without macro dp_mask = 0.
REQ-035 Stop scanning after a frame, TIMEOUT_CYC = 64 -> scan_lost rises 64 cycles after last capture, data unchanged; assert sys_rst mid-frame -> outputs at REQ-026 values immediately.

Source files
------------

// File: rtl/nixie_capture.sv
// nixie_capture -- recovers the digits shown on a multiplexed 8-digit
// 7-segment display by watching its digit enables and segment bus.
//
// Each one-hot digit enable must hold, with an unchanged segment pattern,
// for STABLE_CYC synchronised cycles before that digit is decoded into a
// shadow frame. Once all eight digits have been seen, the shadow frame is
// published on data/masks with a one-cycle frame_valid pulse.
//
// Optional feature: define NIXIE_CAPTURE_DP_EN to capture the decimal
// point of every digit into dp_mask. When it is undefined, no dp storage
// exists and dp_mask is tied to 0.
//
// Parameters:
//   STABLE_CYC   cycles a digit must be stable before capture (>= 2)
//   TIMEOUT_CYC  cycles without a capture before scan_lost asserts
// Ports:
//   sys_clk      clock, all state on rising edge
//   sys_rst      asynchronous active-high reset
//   dig_en[7:0]  digit enables, bit7..0 = h_qw..l_gw
//   smg[7:0]     segments, bit0..6 = a..g, bit7 = dp
//   data[31:0]   last frame, nibble i = digit i (0..9, E glyph error, F blank)
//   blank_mask   digit i was blank in the last frame
//   glyph_err    digit i showed an unknown pattern in the last frame
//   dp_mask      dp lit on digit i in the last frame
//   frame_valid  one-cycle pulse when data/masks update
//   overlap_err  sticky, multi-hot enables were seen
//   scan_lost    no capture for TIMEOUT_CYC cycles

// Per-digit shadow slot: decodes the segment pattern on a write strobe.
// seg_i: segments a..g; wr_i: capture strobe for this digit.
// nib_o/blank_o/glyph_o: decoded value held until the next write.
module nixie_slot (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       wr_i,
  input  logic [6:0] seg_i,
  output logic [3:0] nib_o,
  output logic       blank_o,
  output logic       glyph_o
);
  logic [3:0] nib_d, nib_q;
  logic       blank_d, blank_q;
  logic       glyph_d, glyph_q;

  always_comb begin
    nib_d   = 4'hE;
    blank_d = 1'b0;
    glyph_d = 1'b0;
    case (seg_i)
      7'h3F: nib_d = 4'd0;
      7'h06: nib_d = 4'd1;
      7'h5B: nib_d = 4'd2;
      7'h4F: nib_d = 4'd3;
      7'h66: nib_d = 4'd4;
      7'h6D: nib_d = 4'd5;
      7'h7D: nib_d = 4'd6;
      7'h07: nib_d = 4'd7;
      7'h7F: nib_d = 4'd8;
      7'h6F: nib_d = 4'd9;
      7'h00: begin nib_d = 4'hF; blank_d = 1'b1; end
      default: begin nib_d = 4'hE; glyph_d = 1'b1; end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      nib_q   <= 4'hF;
      blank_q <= 1'b1;
      glyph_q <= 1'b0;
    end else if (wr_i) begin
      nib_q   <= nib_d;
      blank_q <= blank_d;
      glyph_q <= glyph_d;
    end
  end

  assign nib_o   = nib_q;
  assign blank_o = blank_q;
  assign glyph_o = glyph_q;
endmodule

module nixie_capture #(
  parameter int STABLE_CYC  = 16,
  parameter int TIMEOUT_CYC = 1048576
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [7:0]  dig_en,
  input  logic [7:0]  smg,
  output logic [31:0] data,
  output logic [7:0]  blank_mask,
  output logic [7:0]  glyph_err,
  output logic [7:0]  dp_mask,
  output logic        frame_valid,
  output logic        overlap_err,
  output logic        scan_lost
);
  localparam int NUM_DIG = 8;
  localparam int CW = $clog2(STABLE_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  // 2-flop synchronisers, stage [1] is the one the logic uses
  logic [1:0][NUM_DIG-1:0] en_sync_q;
  logic [1:0][7:0]         smg_sync_q;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      en_sync_q  <= '0;
      smg_sync_q <= '0;
    end else begin
      en_sync_q  <= {en_sync_q[0], dig_en};
      smg_sync_q <= {smg_sync_q[0], smg};
    end
  end

  logic [NUM_DIG-1:0] en_s;
  logic [7:0]         smg_s;
  assign en_s  = en_sync_q[1];
  assign smg_s = smg_sync_q[1];

  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic [NUM_DIG-1:0] lat_en_q;
  logic [7:0]         lat_smg_q;
  logic               overlap_q;

  logic en_zero, en_1h, en_multi, chg, cap;

  always_comb begin
    en_zero  = (en_s == '0);
    en_1h    = !en_zero && ((en_s & (en_s - 8'd1)) == '0);
    en_multi = !en_zero && !en_1h;
    chg      = (en_s != lat_en_q) || (smg_s != lat_smg_q);
    // capture on the cycle the counter would reach STABLE_CYC
    cap      = (state_q == SETTLE) && en_1h && !chg &&
               (cnt_q == CW'(STABLE_CYC - 1));
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      lat_en_q  <= '0;
      lat_smg_q <= '0;
      overlap_q <= 1'b0;
    end else if (en_multi) begin
      overlap_q <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (en_1h) begin
            state_q   <= SETTLE;
            cnt_q     <= CW'(1);
            lat_en_q  <= en_s;
            lat_smg_q <= smg_s;
          end
        end
        SETTLE: begin
          if (en_zero) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (chg) begin
            cnt_q     <= CW'(1);
            lat_en_q  <= en_s;
            lat_smg_q <= smg_s;
          end else begin
            cnt_q <= cnt_q + CW'(1);
            if (cap) state_q <= HOLD;
          end
        end
        HOLD: begin
          // wait for the enable to move on so a digit is taken only once
          if (en_s != lat_en_q) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // shadow frame
  logic [NUM_DIG-1:0][3:0] sh_nib;
  logic [NUM_DIG-1:0]      sh_blank, sh_glyph, slot_wr;

  assign slot_wr = cap ? lat_en_q : '0;

  for (genvar i = 0; i < NUM_DIG; i++) begin : g_slot
    nixie_slot u_slot (
      .clk_i   (sys_clk),
      .rst_i   (sys_rst),
      .wr_i    (slot_wr[i]),
      .seg_i   (lat_smg_q[6:0]),
      .nib_o   (sh_nib[i]),
      .blank_o (sh_blank[i]),
      .glyph_o (sh_glyph[i])
    );
  end

  // frame publish and seen tracking
  logic [NUM_DIG-1:0] seen_d, seen_q;
  logic               frame_done;
  logic [31:0]        data_q;
  logic [7:0]         blank_q, glyph_q;
  logic               fv_q;

  assign frame_done = (seen_q == '1);

  always_comb begin
    seen_d = seen_q;
    if (frame_done) seen_d = '0;
    // a capture coinciding with the publish belongs to the new frame
    if (cap) seen_d = seen_d | lat_en_q;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      seen_q  <= '0;
      data_q  <= 32'hFFFF_FFFF;
      blank_q <= 8'hFF;
      glyph_q <= 8'h00;
      fv_q    <= 1'b0;
    end else begin
      seen_q <= seen_d;
      fv_q   <= frame_done;
      if (frame_done) begin
        data_q  <= sh_nib;
        blank_q <= sh_blank;
        glyph_q <= sh_glyph;
      end
    end
  end

`ifdef NIXIE_CAPTURE_DP_EN
  logic [NUM_DIG-1:0] dp_sh_q, dp_q;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      dp_sh_q <= '0;
      dp_q    <= '0;
    end else begin
      if (cap) dp_sh_q <= (dp_sh_q & ~lat_en_q) | (lat_smg_q[7] ? lat_en_q : '0);
      if (frame_done) dp_q <= dp_sh_q;
    end
  end

  assign dp_mask = dp_q;
`else
  assign dp_mask = '0;
`endif

  // scan-loss timeout, saturating
  logic [TW-1:0] to_cnt_d, to_cnt_q;

  always_comb begin
    to_cnt_d = to_cnt_q;
    if (cap) to_cnt_d = '0;
    else if (to_cnt_q != TW'(TIMEOUT_CYC)) to_cnt_d = to_cnt_q + TW'(1);
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) to_cnt_q <= '0;
    else         to_cnt_q <= to_cnt_d;
  end

  assign data        = data_q;
  assign blank_mask  = blank_q;
  assign glyph_err   = glyph_q;
  assign frame_valid = fv_q;
  assign overlap_err = overlap_q;
  assign scan_lost   = (to_cnt_q == TW'(TIMEOUT_CYC));
endmodule

// File: tb/tb_nixie_capture.sv
// Directed bench for nixie_capture: full scans, short digit, overlap,
// glyph/blank decode, dp capture, scan timeout and mid-frame reset.
module tb_nixie_capture;
  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [7:0]  dig_en  = 8'h00;
  logic [7:0]  smg     = 8'h00;
  logic [31:0] data;
  logic [7:0]  blank_mask, glyph_err, dp_mask;
  logic        frame_valid, overlap_err, scan_lost;

  int vectors = 0;
  int miscompares = 0;
  int fv_cnt = 0;
  int base;

  // digit i pattern in [i]: digit 7 = 1 ... digit 0 = 8
  localparam logic [7:0][7:0] PATS = {8'h06, 8'h5B, 8'h4F, 8'h66,
                                      8'h6D, 8'h7D, 8'h07, 8'h7F};

  nixie_capture #(.STABLE_CYC(16), .TIMEOUT_CYC(64)) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .dig_en      (dig_en),
    .smg         (smg),
    .data        (data),
    .blank_mask  (blank_mask),
    .glyph_err   (glyph_err),
    .dp_mask     (dp_mask),
    .frame_valid (frame_valid),
    .overlap_err (overlap_err),
    .scan_lost   (scan_lost)
  );

  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk) if (frame_valid) fv_cnt++;

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic show(input int idx, input logic [7:0] pat, input int cyc);
    dig_en = 8'h01 << idx;
    smg    = pat;
    tick(cyc);
  endtask

  task automatic scan(input logic [7:0][7:0] pats);
    for (int i = 7; i >= 0; i--) show(i, pats[i], 40);
    dig_en = 8'h00;
    smg    = 8'h00;
    tick(8);
  endtask

  task automatic test_reset;
    sys_rst = 1'b1;
    tick(3);
    vectors++; if (data !== 32'hFFFF_FFFF) begin $display("FAIL reset_data: got %h want ffffffff", data); miscompares++; end
    vectors++; if (blank_mask !== 8'hFF) begin $display("FAIL reset_blank: got %h want ff", blank_mask); miscompares++; end
    vectors++; if (glyph_err !== 8'h00) begin $display("FAIL reset_glyph: got %h want 00", glyph_err); miscompares++; end
    vectors++; if (dp_mask !== 8'h00) begin $display("FAIL reset_dp: got %h want 00", dp_mask); miscompares++; end
    vectors++; if (frame_valid !== 1'b0) begin $display("FAIL reset_fv: got %b want 0", frame_valid); miscompares++; end
    vectors++; if (overlap_err !== 1'b0) begin $display("FAIL reset_overlap: got %b want 0", overlap_err); miscompares++; end
    vectors++; if (scan_lost !== 1'b0) begin $display("FAIL reset_lost: got %b want 0", scan_lost); miscompares++; end
    sys_rst = 1'b0;
    tick(2);
  endtask

  task automatic test_frame;
    base = fv_cnt;
    scan(PATS);
    vectors++; if (fv_cnt - base !== 1) begin $display("FAIL frame_fv_count: got %0d want 1", fv_cnt - base); miscompares++; end
    vectors++; if (data !== 32'h1234_5678) begin $display("FAIL frame_data: got %h want 12345678", data); miscompares++; end
    vectors++; if (blank_mask !== 8'h00) begin $display("FAIL frame_blank: got %h want 00", blank_mask); miscompares++; end
    vectors++; if (glyph_err !== 8'h00) begin $display("FAIL frame_glyph: got %h want 00", glyph_err); miscompares++; end
    vectors++; if (dp_mask !== 8'h00) begin $display("FAIL frame_dp: got %h want 00", dp_mask); miscompares++; end
  endtask

  task automatic test_short_digit;
    base = fv_cnt;
    for (int i = 7; i >= 0; i--) show(i, PATS[i], (i == 3) ? 10 : 40);
    dig_en = 8'h00;
    tick(8);
    vectors++; if (fv_cnt - base !== 0) begin $display("FAIL short_no_frame: got %0d want 0", fv_cnt - base); miscompares++; end
    show(3, PATS[3], 40);
    dig_en = 8'h00;
    tick(8);
    vectors++; if (fv_cnt - base !== 1) begin $display("FAIL short_late_frame: got %0d want 1", fv_cnt - base); miscompares++; end
    vectors++; if (data !== 32'h1234_5678) begin $display("FAIL short_data: got %h want 12345678", data); miscompares++; end
  endtask

  task automatic test_overlap;
    base = fv_cnt;
    dig_en = 8'h03;
    smg    = 8'h3F;
    tick(1);
    dig_en = 8'h00;
    tick(6);
    vectors++; if (overlap_err !== 1'b1) begin $display("FAIL overlap_set: got %b want 1", overlap_err); miscompares++; end
    tick(20);
    vectors++; if (overlap_err !== 1'b1) begin $display("FAIL overlap_sticky: got %b want 1", overlap_err); miscompares++; end
    vectors++; if (fv_cnt - base !== 0) begin $display("FAIL overlap_no_frame: got %0d want 0", fv_cnt - base); miscompares++; end
  endtask

  task automatic test_glyph_blank;
    logic [7:0][7:0] p;
    p = {8{8'h3F}};
    p[5] = 8'h49;
    p[0] = 8'h00;
    base = fv_cnt;
    scan(p);
    vectors++; if (fv_cnt - base !== 1) begin $display("FAIL glyph_fv_count: got %0d want 1", fv_cnt - base); miscompares++; end
    vectors++; if (data !== 32'h00E0_000F) begin $display("FAIL glyph_data: got %h want 00e0000f", data); miscompares++; end
    vectors++; if (glyph_err !== 8'h20) begin $display("FAIL glyph_mask: got %h want 20", glyph_err); miscompares++; end
    vectors++; if (blank_mask !== 8'h01) begin $display("FAIL glyph_blank: got %h want 01", blank_mask); miscompares++; end
    vectors++; if (overlap_err !== 1'b1) begin $display("FAIL glyph_overlap_kept: got %b want 1", overlap_err); miscompares++; end
  endtask

  task automatic test_dp;
    logic [7:0][7:0] p;
    logic [7:0]      dp_exp;
`ifdef NIXIE_CAPTURE_DP_EN
    dp_exp = 8'h04;
`else
    dp_exp = 8'h00;
`endif
    p = {8{8'h3F}};
    p[2] = 8'hBF;
    scan(p);
    vectors++; if (data !== 32'h0000_0000) begin $display("FAIL dp_data: got %h want 00000000", data); miscompares++; end
    vectors++; if (dp_mask !== dp_exp) begin $display("FAIL dp_mask: got %h want %h", dp_mask, dp_exp); miscompares++; end
    vectors++; if (glyph_err !== 8'h00) begin $display("FAIL dp_glyph: got %h want 00", glyph_err); miscompares++; end
  endtask

  task automatic test_timeout;
    // capture lands 18 edges after the enable is driven; scan_lost 64 later
    dig_en = 8'h01;
    smg    = 8'h3F;
    tick(81);
    vectors++; if (scan_lost !== 1'b0) begin $display("FAIL lost_early: got %b want 0", scan_lost); miscompares++; end
    tick(1);
    vectors++; if (scan_lost !== 1'b1) begin $display("FAIL lost_rise: got %b want 1", scan_lost); miscompares++; end
    tick(10);
    vectors++; if (scan_lost !== 1'b1) begin $display("FAIL lost_hold: got %b want 1", scan_lost); miscompares++; end
    vectors++; if (data !== 32'h0000_0000) begin $display("FAIL lost_data_kept: got %h want 00000000", data); miscompares++; end
    dig_en = 8'h00;
    tick(4);
  endtask

  task automatic test_reset_midframe;
    for (int i = 7; i >= 4; i--) show(i, PATS[i], 40);
    sys_rst = 1'b1;
    #2;
    vectors++; if (data !== 32'hFFFF_FFFF) begin $display("FAIL mid_rst_data: got %h want ffffffff", data); miscompares++; end
    vectors++; if (blank_mask !== 8'hFF) begin $display("FAIL mid_rst_blank: got %h want ff", blank_mask); miscompares++; end
    vectors++; if (overlap_err !== 1'b0) begin $display("FAIL mid_rst_overlap: got %b want 0", overlap_err); miscompares++; end
    vectors++; if (scan_lost !== 1'b0) begin $display("FAIL mid_rst_lost: got %b want 0", scan_lost); miscompares++; end
    dig_en = 8'h00;
    tick(2);
    sys_rst = 1'b0;
    tick(2);
    base = fv_cnt;
    for (int i = 3; i >= 0; i--) show(i, PATS[i], 40);
    dig_en = 8'h00;
    tick(8);
    vectors++; if (fv_cnt - base !== 0) begin $display("FAIL mid_partial_discard: got %0d want 0", fv_cnt - base); miscompares++; end
    scan(PATS);
    vectors++; if (fv_cnt - base !== 1) begin $display("FAIL mid_fresh_frame: got %0d want 1", fv_cnt - base); miscompares++; end
    vectors++; if (data !== 32'h1234_5678) begin $display("FAIL mid_fresh_data: got %h want 12345678", data); miscompares++; end
  endtask

  initial begin
    test_reset;
    test_frame;
    test_short_digit;
    test_overlap;
    test_glyph_blank;
    test_dp;
    test_timeout;
    test_reset_midframe;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
